// File: rtl/layer_seq_ctrl.sv
// Sequencer for one fully-connected layer pass: walks (input, neuron) pairs,
// issues memory reads and drives the accumulator and output register enables.
module layer_seq_ctrl #(
  parameter int DWIDTH = 16,
  parameter int NIN    = 64,
  parameter int NOUT   = 10,
  parameter int AW     = 6,
  parameter int NW     = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] in_addr,
  output logic [NW-1:0] nrn_addr,
  output logic          mac_en,
  output logic          acc_clr,
  output logic          out_en,
  output logic [NW-1:0] out_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [AW-1:0] LAST_I = AW'(NIN - 1);
  localparam logic [NW-1:0] LAST_J = NW'(NOUT - 1);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_i, w_i_nxt, w_ci;
  logic [NW-1:0] r_j, w_j_nxt, w_cj;
  logic          w_issue;
  logic          w_busy_nxt, w_done_nxt, w_rd_nxt;
  logic [AW-1:0] w_in_addr_nxt;
  logic [NW-1:0] w_nrn_nxt;
  logic          r_last_p1;
  logic [NW-1:0] r_nrn_p1;

  always_comb begin
    w_state_nxt   = r_state;
    w_i_nxt       = r_i;
    w_j_nxt       = r_j;
    w_ci          = r_i;
    w_cj          = r_j;
    w_issue       = 1'b0;
    w_busy_nxt    = busy;
    w_done_nxt    = 1'b0;
    w_rd_nxt      = 1'b0;
    w_in_addr_nxt = in_addr;
    w_nrn_nxt     = nrn_addr;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_busy_nxt  = 1'b1;
          w_ci        = '0;
          w_cj        = '0;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
          w_issue     = !stall;
        end
      end
      S_RUN: begin
        w_busy_nxt = 1'b1;
        w_issue    = !stall;
      end
      S_DRAIN: begin
        // Only the last neuron's output write ends the pass.
        if (out_en && (out_idx == LAST_J)) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_issue) begin
      w_rd_nxt      = 1'b1;
      w_in_addr_nxt = w_ci;
      w_nrn_nxt     = w_cj;
      if (w_ci == LAST_I) begin
        w_i_nxt = '0;
        if (w_cj == LAST_J) begin
          w_j_nxt     = '0;
          w_state_nxt = S_DRAIN;
        end else begin
          w_j_nxt = w_cj + NW'(1);
        end
      end else begin
        w_i_nxt = w_ci + AW'(1);
      end
    end
  end

  // Stage p0: FSM, counters and read issue
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_i      <= '0;
      r_j      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      in_addr  <= '0;
      nrn_addr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_i      <= w_i_nxt;
      r_j      <= w_j_nxt;
      busy     <= w_busy_nxt;
      done     <= w_done_nxt;
      rd_en    <= w_rd_nxt;
      in_addr  <= w_in_addr_nxt;
      nrn_addr <= w_nrn_nxt;
    end
  end

  // Stage p1: accumulate enables; stage p2: output register write
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mac_en    <= 1'b0;
      acc_clr   <= 1'b0;
      r_last_p1 <= 1'b0;
      out_en    <= 1'b0;
      out_idx   <= '0;
    end else begin
      mac_en    <= rd_en;
      acc_clr   <= rd_en && (in_addr == '0);
      r_last_p1 <= rd_en && (in_addr == LAST_I);
      out_en    <= r_last_p1;
      if (r_last_p1) out_idx <= r_nrn_p1;
    end
  end

  always_ff @(posedge clk) begin
    r_nrn_p1 <= nrn_addr;
  end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Directed bench for layer_seq_ctrl: a 4x2 instance and a 1x3 instance,
// checked cycle by cycle against hand-written per-cycle masks.
module tb_layer_seq_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       stall;
  logic       start1, start2;
  logic       busy1, done1, rd_en1, mac_en1, acc_clr1, out_en1;
  logic [5:0] in_addr1;
  logic [3:0] nrn_addr1, out_idx1;
  logic       busy2, done2, rd_en2, mac_en2, acc_clr2, out_en2;
  logic [5:0] in_addr2;
  logic [3:0] nrn_addr2, out_idx2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  layer_seq_ctrl #(.DWIDTH(16), .NIN(4), .NOUT(2), .AW(6), .NW(4)) u_dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .stall(stall),
    .busy(busy1), .done(done1), .rd_en(rd_en1), .in_addr(in_addr1),
    .nrn_addr(nrn_addr1), .mac_en(mac_en1), .acc_clr(acc_clr1),
    .out_en(out_en1), .out_idx(out_idx1)
  );

  layer_seq_ctrl #(.DWIDTH(16), .NIN(1), .NOUT(3), .AW(6), .NW(4)) u_dut2 (
    .clk(clk), .resetn(resetn), .start(start2), .stall(stall),
    .busy(busy2), .done(done2), .rd_en(rd_en2), .in_addr(in_addr2),
    .nrn_addr(nrn_addr2), .mac_en(mac_en2), .acc_clr(acc_clr2),
    .out_en(out_en2), .out_idx(out_idx2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs ncyc edges from a start at edge 0; mask bit c describes cycle c.
  task automatic run_check(input string nm, input bit sel, input int ncyc,
                           input logic [15:0] stall_m, input int extra_start,
                           input logic [15:0] rm, input logic [15:0] mm,
                           input logic [15:0] am, input logic [15:0] om,
                           input logic [15:0] bm, input logic [15:0] dm,
                           input int ni);
    int rd_n;
    int out_n;
    logic [5:0] ctl;
    logic [9:0] adr;
    logic [3:0] oidx;
    rd_n  = 0;
    out_n = 0;
    for (int k = 0; k < ncyc; k++) begin
      stall = stall_m[k];
      if (sel) start2 = (k == 0);
      else     start1 = (k == 0) || (k == extra_start);
      @(posedge clk);
      #1;
      stall  = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
      if (sel) begin
        ctl  = {busy2, done2, rd_en2, mac_en2, acc_clr2, out_en2};
        adr  = {in_addr2, nrn_addr2};
        oidx = out_idx2;
      end else begin
        ctl  = {busy1, done1, rd_en1, mac_en1, acc_clr1, out_en1};
        adr  = {in_addr1, nrn_addr1};
        oidx = out_idx1;
      end
      chk($sformatf("%s c%0d ctl", nm, k + 1), 32'(ctl),
          32'({bm[k+1], dm[k+1], rm[k+1], mm[k+1], am[k+1], om[k+1]}));
      if (rm[k+1]) begin
        chk($sformatf("%s c%0d addr", nm, k + 1), 32'(adr),
            32'({6'(rd_n % ni), 4'(rd_n / ni)}));
        rd_n++;
      end
      if (om[k+1]) begin
        chk($sformatf("%s c%0d out_idx", nm, k + 1), 32'(oidx), 32'(out_n));
        out_n++;
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    stall  = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    #22;
    chk("reset dut1", 32'({busy1, done1, rd_en1, in_addr1, nrn_addr1, mac_en1,
                           acc_clr1, out_en1, out_idx1}), 32'd0);
    chk("reset dut2", 32'({busy2, done2, rd_en2, in_addr2, nrn_addr2, mac_en2,
                           acc_clr2, out_en2, out_idx2}), 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    //               name       sel ncyc stall    xstart rd       mac      clr      out      busy     done     nin
    run_check("nominal",   1'b0, 13, 16'h0000, -1, 16'h01FE, 16'h03FC, 16'h0044, 16'h0440, 16'h07FE, 16'h0800, 4);
    run_check("stall2",    1'b0, 14, 16'h0004, -1, 16'h03F6, 16'h07EC, 16'h0084, 16'h0880, 16'h0FFE, 16'h1000, 4);
    run_check("startbusy", 1'b0, 14, 16'h0000,  5, 16'h01FE, 16'h03FC, 16'h0044, 16'h0440, 16'h07FE, 16'h0800, 4);
    run_check("startstall",1'b0, 14, 16'h0001, -1, 16'h03FC, 16'h07F8, 16'h0088, 16'h0880, 16'h0FFE, 16'h1000, 4);
    run_check("nin1",      1'b1,  8, 16'h0000, -1, 16'h000E, 16'h001C, 16'h001C, 16'h0038, 16'h003E, 16'h0040, 1);

    // Asynchronous reset in cycle 4 of a pass
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midpass rd_en", 32'({busy1, rd_en1}), 32'h3);
    #2;
    resetn = 1'b0;
    #1;
    chk("async reset", 32'({busy1, done1, rd_en1, in_addr1, nrn_addr1, mac_en1,
                            acc_clr1, out_en1, out_idx1}), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post reset c%0d", k), 32'({busy1, done1, rd_en1, mac_en1,
                                               acc_clr1, out_en1}), 32'd0);
    end
    run_check("restart",   1'b0, 13, 16'h0000, -1, 16'h01FE, 16'h03FC, 16'h0044, 16'h0440, 16'h07FE, 16'h0800, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_seq_ctrl.md
LAYER_SEQ_CTRL -- requirements
Module: layer_seq_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DWIDTH, 16: datapath word width of the sequenced MAC/register datapath; no internal use beyond documentation.
- NIN, 64: inputs per neuron; valid range NIN >= 1.
- NOUT, 10: neurons per layer; valid range NOUT >= 1.
- AW, 6: in_addr width; AW >= clog2(NIN).
- NW, 4: nrn_addr/out_idx width; NW >= clog2(NOUT).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: single clock; all state changes on its rising edge.
- resetn, in, 1: asynchronous, active-low reset.
- start, in, 1: begin one layer pass; sampled only in IDLE.
- stall, in, 1: suppresses issuing a new read at the sampling edge.
- busy, out, 1: pass in progress.
- done, out, 1: one-cycle pulse at pass completion.
- rd_en, out, 1: weight/input memory read strobe.
- in_addr, out, AW: input index i of the current read.
- nrn_addr, out, NW: neuron index j of the current read.
- mac_en, out, 1: accumulator register enable.
- acc_clr, out, 1: accumulator load-not-add for the first product of a neuron.
- out_en, out, 1: output register enable.
- out_idx, out, NW: neuron index written by out_en.
REQ-003 All outputs SHALL be registered.

Function
REQ-004 States SHALL be IDLE, RUN, DRAIN; busy SHALL be 1 in RUN and DRAIN only.
REQ-005 IDLE: at an edge with start=1, go to RUN, clear i=0 and j=0; issue read (0,0) at that same edge unless stall=1. stall does not block start acceptance.
REQ-006 RUN, at each edge: if stall=0, drive rd_en=1, in_addr=i, nrn_addr=j for the following cycle, then advance i. If stall=1, drive rd_en=0 and hold i and j.
REQ-007 Counter wrap: after issuing i=NIN-1, i SHALL wrap to 0 and j SHALL increment. After issuing (NIN-1, NOUT-1), go to DRAIN. Counters SHALL never exceed NIN-1 or NOUT-1.
REQ-008 mac_en SHALL equal rd_en delayed one cycle. acc_clr SHALL be 1 exactly when mac_en=1 and the delayed in_addr was 0.
REQ-009 out_en SHALL pulse for one cycle, one cycle after the mac_en whose delayed in_addr was NIN-1. out_idx SHALL carry that read's nrn_addr. out_idx SHALL hold its value otherwise.
REQ-010 stall SHALL NOT delay mac_en or out_en of reads already issued.
REQ-011 DRAIN: on the edge after the final out_en cycle, go to IDLE with busy=0 and done=1 for one cycle.
REQ-012 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-013 Pass without stalls: reads in cycles 1..NIN*NOUT, counting from the start edge as cycle 0. Final out_en at NIN*NOUT+2, done at NIN*NOUT+3. Each stalled edge in RUN adds exactly one cycle.
REQ-014 NIN=1: every mac_en SHALL have acc_clr=1, and out_en SHALL follow each mac_en by one cycle.

Reset
REQ-015 resetn=0 SHALL immediately force state IDLE, i=j=0, and all outputs to 0 (busy, done, rd_en, in_addr, nrn_addr, mac_en, acc_clr, out_en, out_idx), independent of clk.
REQ-016 Reset mid-pass SHALL abort the pass with no further rd_en, mac_en, out_en or done. The first edge after release with start=1 SHALL begin a fresh pass at (0,0).

Verification
REQ-017 Nominal pass, NIN=4, NOUT=2, start at edge 0, stall=0:
- rd_en in cycles 1-8 with (i,j) = (0,0)..(3,0),(0,1)..(3,1);
- acc_clr in cycles 2 and 6;
- out_en in cycle 6 (out_idx=0) and cycle 10 (out_idx=1);
- done in cycle 11; busy cycles 1-10.
REQ-018 Stall, same configuration, stall=1 sampled at edge 2 only: no read in cycle 3; reads in cycles 1, 2, 4-9; out_en in cycles 7 and 11; done in cycle 12.
REQ-019 Start while busy, start pulsed in cycle 5 of a nominal pass: no effect; exactly 8 reads and a single done.
REQ-020 Reset mid-pass, resetn=0 asynchronously in cycle 4: all outputs 0 within the same cycle; no out_en after release; a new start yields a full nominal pass.
REQ-021 Corner cases: NIN=1, NOUT=3 gives reads in cycles 1-3, acc_clr=mac_en in cycles 2-4, out_en in cycles 3-5 (out_idx 0,1,2), done in cycle 6. start and stall both 1 at edge 0 gives first read in cycle 2.
